// File: rtl/sv_trigger_gen.sv
// sv_trigger_gen: camera/acquisition trigger generator.
// Two asynchronous event sources are synchronised and edge-detected. The
// synchronised en_enc level selects the source: the external line, or
// encoder steps divided by ENC_DIV. A candidate event starts a fixed-width
// o_trigger pulse. A holdoff window follows each pulse. Events that arrive
// while a pulse or holdoff is active are dropped, not queued.
//
// Event handshake: w_cand is a single-cycle strobe registered into r_cand.
// The output FSM consumes r_cand only in S_IDLE and never back-pressures
// the sources. The FSM state is visible on r_state for external checkers.
module sv_trigger_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_WIDTH = 4,
  parameter int HOLDOFF     = 8,
  parameter int ENC_DIV     = 1
) (
  input  logic i_clk,
  input  logic i_aresetn,
  input  logic ext_input,
  input  logic encoder_step_input,
  input  logic en_enc_input,
  output logic o_trigger
);

  localparam int STEP_W = (ENC_DIV > 1) ? $clog2(ENC_DIV) : 1;
  localparam int CMAX   = (PULSE_WIDTH > HOLDOFF) ? PULSE_WIDTH : HOLDOFF;
  localparam int CNT_W  = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(ENC_DIV - 1);
  localparam logic [CNT_W-1:0]  PW_LOAD  = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0]  HO_LOAD  = CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_ext_sync;
  logic [SYNC_STAGES-1:0] r_enc_sync;
  logic [SYNC_STAGES-1:0] r_en_sync;
  logic                   r_ext_prev;
  logic                   r_enc_prev;
  logic [STEP_W-1:0]      r_step_cnt;
  logic                   r_cand;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_trigger;

  logic                   w_ext_s;
  logic                   w_enc_s;
  logic                   w_en_s;
  logic                   w_ext_rise;
  logic                   w_enc_rise;
  logic                   w_enc_evt;
  logic                   w_cand;
  state_t                 w_next_state;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_trig_next;

  // Synchroniser chains, one per asynchronous input; the MSB is the synchronised value
  always_ff @(posedge i_clk) begin
    if (i_aresetn) begin
      r_ext_sync <= '0;
      r_enc_sync <= '0;
      r_en_sync  <= '0;
    end else begin
      r_ext_sync <= {r_ext_sync[SYNC_STAGES-2:0], ext_input};
      r_enc_sync <= {r_enc_sync[SYNC_STAGES-2:0], encoder_step_input};
      r_en_sync  <= {r_en_sync[SYNC_STAGES-2:0], en_enc_input};
    end
  end

  assign w_ext_s    = r_ext_sync[SYNC_STAGES-1];
  assign w_enc_s    = r_enc_sync[SYNC_STAGES-1];
  assign w_en_s     = r_en_sync[SYNC_STAGES-1];
  assign w_ext_rise = w_ext_s & ~r_ext_prev;
  assign w_enc_rise = w_enc_s & ~r_enc_prev;

  // Previous synchronised values for rising-edge detection
  always_ff @(posedge i_clk) begin
    if (i_aresetn) begin
      r_ext_prev <= 1'b0;
      r_enc_prev <= 1'b0;
    end else begin
      r_ext_prev <= w_ext_s;
      r_enc_prev <= w_enc_s;
    end
  end

  // Encoder step divider: counts while in encoder mode and wraps on the ENC_DIV-th step.
  // It keeps counting during pulse and holdoff and clears whenever external mode is selected.
  always_ff @(posedge i_clk) begin
    if (i_aresetn) begin
      r_step_cnt <= '0;
    end else if (!w_en_s) begin
      r_step_cnt <= '0;
    end else if (w_enc_rise) begin
      r_step_cnt <= (r_step_cnt == STEP_MAX) ? '0 : r_step_cnt + 1'b1;
    end
  end

  assign w_enc_evt = w_enc_rise & (r_step_cnt == STEP_MAX);
  assign w_cand    = w_en_s ? w_enc_evt : w_ext_rise;

  // Registered candidate event; the extra stage gives the input-to-trigger latency of SYNC_STAGES+1
  always_ff @(posedge i_clk) begin
    if (i_aresetn) r_cand <= 1'b0;
    else           r_cand <= w_cand;
  end

  // FSM state register and shared pulse/holdoff down-counter
  always_ff @(posedge i_clk) begin
    if (i_aresetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic; the counter is loaded on entry to PULSE and HOLD and decremented otherwise
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = (r_cnt != '0) ? r_cnt - 1'b1 : '0;
    case (r_state)
      S_IDLE: begin
        if (r_cand) begin
          w_next_state = S_PULSE;
          w_cnt_next   = PW_LOAD;
        end
      end
      S_PULSE: begin
        if (r_cnt == '0) begin
          if (HOLDOFF == 0) begin
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_HOLD;
            w_cnt_next   = HO_LOAD;
          end
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Output decode: the trigger is high exactly while the FSM is in PULSE
  always_comb begin
    w_trig_next = (w_next_state == S_PULSE);
  end

  // Registered trigger output; reset drops it on the same edge
  always_ff @(posedge i_clk) begin
    if (i_aresetn) r_trigger <= 1'b0;
    else           r_trigger <= w_trig_next;
  end

  assign o_trigger = r_trigger;

endmodule

// File: tb/tb_sv_trigger_gen.sv
// Testbench for sv_trigger_gen. A per-cycle vector table drives the
// default-parameter instance. A second instance with ENC_DIV=3 shares the
// inputs and is checked by a hand-written encoder divider sequence.
module tb_sv_trigger_gen;

  localparam int NV = 220;

  typedef struct {
    logic rst;
    logic ext;
    logic enc;
    logic en;
    logic exp_trig;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic ext;
  logic enc;
  logic en;
  logic trig;
  logic trig_div;

  int errors = 0;
  int checks = 0;

  vec_t vec [NV];

  // Clock and reset
  always #5 clk = ~clk;

  sv_trigger_gen u_dut (
    .i_clk              (clk),
    .i_aresetn          (rst),
    .ext_input          (ext),
    .encoder_step_input (enc),
    .en_enc_input       (en),
    .o_trigger          (trig)
  );

  sv_trigger_gen #(.ENC_DIV(3)) u_div (
    .i_clk              (clk),
    .i_aresetn          (rst),
    .ext_input          (ext),
    .encoder_step_input (enc),
    .en_enc_input       (en),
    .o_trigger          (trig_div)
  );

  // Scoreboard compare
  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Table helpers: a 1-cycle input at row r gives trigger on rows r+4..r+7
  task automatic exp_pulse(input int r);
    for (int i = 0; i < 4; i++) vec[r + 4 + i].exp_trig = 1'b1;
  endtask

  task automatic set_en(input int from_r, input int to_r, input logic v);
    for (int i = from_r; i <= to_r; i++) vec[i].en = v;
  endtask

  // Driver: one encoder step, then count trigger rising edges on both instances
  task automatic step_enc(output int rises, output int rises_div);
    logic p;
    logic pd;
    rises     = 0;
    rises_div = 0;
    @(negedge clk);
    enc = 1'b1;
    @(negedge clk);
    enc = 1'b0;
    p  = trig;
    pd = trig_div;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (trig && !p)      rises++;
      if (trig_div && !pd) rises_div++;
      p  = trig;
      pd = trig_div;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int r;
    int rd;
    rst = 1'b1;
    ext = 1'b0;
    enc = 1'b0;
    en  = 1'b0;

    // Build the vector table
    for (int i = 0; i < NV; i++) vec[i] = '{rst: 1'b0, ext: 1'b0, enc: 1'b0, en: 1'b0, exp_trig: 1'b0};
    for (int i = 0; i < 10; i++) begin
      vec[i].rst = 1'b1;
      if (i < 8) begin
        vec[i].ext = i[0];
        vec[i].enc = i[1];
        vec[i].en  = i[2];
      end
    end
    // Single external pulse
    vec[12].ext = 1'b1;
    exp_pulse(12);
    // Reset in the 2nd pulse cycle; ext held only during reset must not fire
    vec[30].ext = 1'b1;
    vec[34].exp_trig = 1'b1;
    vec[35].exp_trig = 1'b1;
    vec[35].rst = 1'b1;
    vec[36].rst = 1'b1;
    vec[35].ext = 1'b1;
    vec[36].ext = 1'b1;
    vec[42].ext = 1'b1;
    exp_pulse(42);
    // Encoder ignored in external mode
    vec[55].enc = 1'b1;
    // Encoder mode: encoder fires, ext ignored
    set_en(60, 99, 1'b1);
    vec[70].enc = 1'b1;
    exp_pulse(70);
    vec[85].ext = 1'b1;
    // Holdoff: second pulse 5 cycles later dropped
    vec[110].ext = 1'b1;
    vec[115].ext = 1'b1;
    exp_pulse(110);
    // Pulses 16 cycles apart both fire
    vec[130].ext = 1'b1;
    vec[146].ext = 1'b1;
    exp_pulse(130);
    exp_pulse(146);
    // Steady-high input gives exactly one event
    for (int i = 160; i <= 180; i++) vec[i].ext = 1'b1;
    exp_pulse(160);
    // Simultaneous edges: external selected
    vec[190].ext = 1'b1;
    vec[190].enc = 1'b1;
    exp_pulse(190);
    // Simultaneous edges: encoder selected
    set_en(200, NV - 1, 1'b1);
    vec[206].ext = 1'b1;
    vec[206].enc = 1'b1;
    exp_pulse(206);

    // Apply the table: compare, then drive the row inputs
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      check_int($sformatf("row%0d", i), int'(trig), int'(vec[i].exp_trig));
      rst = vec[i].rst;
      ext = vec[i].ext;
      enc = vec[i].enc;
      en  = vec[i].en;
    end

    // Divider sequence (ENC_DIV=3 instance)
    @(negedge clk);
    rst = 1'b1;
    ext = 1'b0;
    enc = 1'b0;
    en  = 1'b1;
    idle_cycles(3);
    rst = 1'b0;
    idle_cycles(5);
    for (int s = 1; s <= 7; s++) begin
      step_enc(r, rd);
      check_int($sformatf("div_step%0d", s), rd, (s % 3 == 0) ? 1 : 0);
      check_int($sformatf("div1_step%0d", s), r, 1);
    end
    // Leaving encoder mode clears the step counter
    en = 1'b0;
    idle_cycles(6);
    en = 1'b1;
    idle_cycles(6);
    for (int s = 1; s <= 2; s++) begin
      step_enc(r, rd);
      check_int($sformatf("div_clr_step%0d", s), rd, 0);
      check_int($sformatf("div1_clr_step%0d", s), r, 1);
    end

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sv_trigger_gen.md
Name: sv_trigger_gen

Overview:
- Camera/acquisition trigger generator. Selects one of two asynchronous event sources: an external trigger line, or an encoder step line gated by an enable.
- Synchronises and edge-detects the selected source, optionally divides encoder steps, and emits a fixed-width, rate-limited trigger pulse on o_trigger.
- Sits between board-level trigger/encoder inputs and the sensor/capture logic.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchroniser stages per asynchronous input (minimum 2).
- PULSE_WIDTH, 4, o_trigger high time in i_clk cycles (minimum 1).
- HOLDOFF, 8, cycles after pulse end during which new events are dropped (0 allowed).
- ENC_DIV, 1, one trigger per ENC_DIV encoder rising edges (minimum 1).

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_aresetn  input  1  reset; synchronous, active-high (1 = reset).
- ext_input  input  1  external trigger, asynchronous; rising edge = event.
- encoder_step_input  input  1  encoder step, asynchronous; rising edge = one step.
- en_enc_input  input  1  source select, asynchronous-safe level: 1 = encoder mode, 0 = external mode.
- o_trigger  output  1  registered trigger pulse.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset while i_aresetn=1 at a rising edge clears:
  - all synchroniser and edge-detect registers to 0;
  - the step counter to 0;
  - the pulse and holdoff counters to 0;
  - o_trigger to 0.
- Reset mid-pulse: o_trigger goes 0 on that same edge, and any pending event is lost.
- Synchronisation: ext_input, encoder_step_input and en_enc_input each pass through SYNC_STAGES flops.
- Edge detect: a rising edge is a synchronised value of 1 where the previous synchronised value was 0. Each edge is a one-cycle event.
- Source mux (uses the synchronised en_enc):
  - en_enc=0: external edges are candidate events; encoder edges are ignored.
  - en_enc=1: encoder edges increment the step counter, and external edges are ignored.
  - When the counter reaches ENC_DIV-1 and another edge arrives, the counter wraps to 0 and a candidate event is produced. With ENC_DIV=1, every encoder edge is an event.
  - The step counter clears to 0 whenever synchronised en_enc=0.
- Output FSM states: IDLE, PULSE, HOLDOFF.
  - IDLE + candidate event -> PULSE. o_trigger=1 from the next edge, and the pulse counter loads PULSE_WIDTH-1.
  - PULSE: o_trigger stays 1 and the counter decrements. When it reaches 0, go to HOLDOFF with counter=HOLDOFF-1, or go directly to IDLE if HOLDOFF=0. o_trigger is 0 outside PULSE.
  - HOLDOFF: decrement; at 0 -> IDLE.
- Events arriving in PULSE or HOLDOFF are dropped, not queued. In encoder mode the step counter keeps counting during these states.
- Latency: input first sampled high at edge N produces o_trigger=1 at edge N+SYNC_STAGES+1, i.e. N+3 with defaults. Pulse lasts exactly PULSE_WIDTH cycles.
- Input pulses shorter than one i_clk period may be missed; the source must hold each level at least 2 cycles to be guaranteed.
- Mode switch: a change of en_enc takes effect SYNC_STAGES cycles later. It does not truncate a pulse already in progress.
- Simultaneous ext and encoder edges: only the selected source counts.
- Steady-high input produces exactly one event.
- X-free: all registers have reset values; no latches.

Test Plan:
- Reset: hold i_aresetn=1 for 10 cycles while toggling all inputs -> o_trigger=0 throughout.
- External trigger (defaults, en_enc=0): ext_input high 1 cycle at edge N -> o_trigger=1 on edges N+3..N+6, 0 after.
- Encoder gating: en_enc=0 with an encoder pulse -> no trigger. Then en_enc=1 with a 1-cycle encoder pulse -> 4-cycle trigger 3 cycles later. An ext pulse during en_enc=1 -> no trigger.
- Divider (ENC_DIV=3): 7 encoder pulses spaced 20 cycles apart -> exactly 2 triggers, on the 3rd and 6th steps. Drop en_enc, re-enable, then 2 steps -> no trigger, because the counter was cleared.
- Holdoff: two ext pulses 5 cycles apart -> one trigger. Two pulses 12+ cycles apart (PULSE_WIDTH+HOLDOFF) -> two triggers.
- Reset mid-pulse: assert i_aresetn during the 2nd pulse cycle -> o_trigger 0 at that edge. A fresh ext pulse after release -> normal 4-cycle pulse.
